// File: rtl/lsu_axi_ctrl.sv
// Load/store unit bridging the execute stage to an AXI4-Lite data port.
// One operation in flight; lane alignment, fault reporting and result hold until write-back.
module lsu_axi_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 80
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_ren,
    input  logic                in_wen,
    input  logic [1:0]          in_size,
    input  logic                in_signed,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_fault,
    output logic                busy,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);
    localparam int NB       = DATA_W / 8;
    localparam int OFF_W    = $clog2(NB);
    localparam int MAX_SIZE = $clog2(NB);

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B, DONE} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [TAG_W-1:0]  tag_q;
    logic              fault_q;
    logic              aw_done;
    logic              w_done;

    logic              accept;
    logic              misaligned;
    logic [2:0]        align_mask;
    logic              aw_hs;
    logic              w_hs;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] load_sh;
    logic [DATA_W-1:0] load_ext;
    logic              sign_bit;
    int                nbits;
    int                lane_mask;
    logic [NB-1:0]     base_strb;

    assign accept = in_valid && in_ready;
    assign aw_hs  = (state == WR_A) && !aw_done && awready;
    assign w_hs   = (state == WR_A) && !w_done && wready;
    assign off    = addr_q[OFF_W-1:0];

    always_comb begin
        align_mask = 3'b000;
        case (in_size)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        // a dword request on a 32-bit bus cannot be served, so it faults like a misalignment
        misaligned = ((in_addr[2:0] & align_mask) != 3'b000) || (int'(in_size) > MAX_SIZE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        arvalid  = 1'b0;
        rready   = 1'b0;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        bready   = 1'b0;
        out_valid = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if ((in_ren || in_wen) && misaligned) state_nx = DONE;
                    else if (in_ren)                      state_nx = RD_A;
                    else if (in_wen)                      state_nx = WR_A;
                    else                                  state_nx = DONE;
                end
            end
            RD_A: begin
                arvalid = 1'b1;
                if (arready) state_nx = RD_D;
            end
            RD_D: begin
                rready = 1'b1;
                if (rvalid) state_nx = DONE;
            end
            WR_A: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = WR_B;
            end
            WR_B: begin
                bready = 1'b1;
                if (bvalid) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shift the addressed lane down, then extend from the access width.
    always_comb begin
        load_sh  = rdata >> (8 * off);
        nbits    = DATA_W;
        sign_bit = 1'b0;
        case (size_q)
            2'd0:    begin nbits = 8;  sign_bit = load_sh[7];        end
            2'd1:    begin nbits = 16; sign_bit = load_sh[15];       end
            2'd2:    begin nbits = 32; sign_bit = load_sh[31];       end
            default: begin nbits = DATA_W; sign_bit = load_sh[DATA_W-1]; end
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            load_ext[i] = (i < nbits) ? load_sh[i] : (signed_q & sign_bit);
        end
    end

    always_comb begin
        lane_mask = (1 << size_q) - 1;
        if (lane_mask > NB - 1) lane_mask = NB - 1;
        for (int i = 0; i < NB; i++) begin
            base_strb[i]        = (i <= lane_mask);
            wdata[8*i +: 8]     = wdata_q[8*(i & lane_mask) +: 8];
        end
        wstrb = base_strb << off;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            tag_q    <= '0;
            fault_q  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= in_addr;
                size_q   <= in_size;
                signed_q <= in_signed;
                wdata_q  <= in_wdata;
                tag_q    <= in_tag;
                rdata_q  <= '0;
                fault_q  <= (in_ren || in_wen) && misaligned;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (state == RD_D && rvalid) begin
                fault_q <= (rresp != 2'b00);
                rdata_q <= (rresp != 2'b00) ? '0 : load_ext;
            end
            if (state == WR_B && bvalid) begin
                fault_q <= (bresp != 2'b00);
            end
        end
    end

    assign araddr    = addr_q;
    assign awaddr    = addr_q;
    assign out_rdata = rdata_q;
    assign out_tag   = tag_q;
    assign out_fault = fault_q;

endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// Directed bench for lsu_axi_ctrl: a 32-bit instance driven from a vector table,
// plus a 64-bit instance for wide-lane stores/loads and hand-written corner sequences.
module tb_lsu_axi_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_ren, in_wen, in_signed;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic [79:0] in_tag, out_tag;
    logic        out_valid, out_ready, out_fault, busy;
    logic [31:0] out_rdata;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    lsu_axi_ctrl #(.DATA_W(32), .ADDR_W(32), .TAG_W(80)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
        .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_tag(out_tag), .out_fault(out_fault), .busy(busy),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    logic        d64_in_valid, d64_in_ready, d64_in_ren, d64_in_wen, d64_in_signed;
    logic [1:0]  d64_in_size;
    logic [31:0] d64_in_addr, d64_araddr, d64_awaddr;
    logic [63:0] d64_in_wdata, d64_out_rdata, d64_rdata, d64_wdata;
    logic [79:0] d64_in_tag, d64_out_tag;
    logic        d64_out_valid, d64_out_ready, d64_out_fault, d64_busy;
    logic        d64_arvalid, d64_arready, d64_rvalid, d64_rready, d64_awvalid, d64_awready;
    logic        d64_wvalid, d64_wready, d64_bvalid, d64_bready;
    logic [1:0]  d64_rresp, d64_bresp;
    logic [7:0]  d64_wstrb;

    lsu_axi_ctrl #(.DATA_W(64), .ADDR_W(32), .TAG_W(80)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(d64_in_valid), .in_ready(d64_in_ready), .in_ren(d64_in_ren), .in_wen(d64_in_wen),
        .in_size(d64_in_size), .in_signed(d64_in_signed), .in_addr(d64_in_addr),
        .in_wdata(d64_in_wdata), .in_tag(d64_in_tag), .out_valid(d64_out_valid),
        .out_ready(d64_out_ready), .out_rdata(d64_out_rdata), .out_tag(d64_out_tag),
        .out_fault(d64_out_fault), .busy(d64_busy),
        .araddr(d64_araddr), .arvalid(d64_arvalid), .arready(d64_arready),
        .rdata(d64_rdata), .rresp(d64_rresp), .rvalid(d64_rvalid), .rready(d64_rready),
        .awaddr(d64_awaddr), .awvalid(d64_awvalid), .awready(d64_awready),
        .wdata(d64_wdata), .wstrb(d64_wstrb), .wvalid(d64_wvalid), .wready(d64_wready),
        .bresp(d64_bresp), .bvalid(d64_bvalid), .bready(d64_bready)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        logic        exp_ar;
        logic        exp_w;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[12];
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int          lat, ar_n, aw_n, w_n;
        logic [31:0] ar_a, aw_a, w_d;
        logic [3:0]  w_s;
        logic [79:0] tag;
        tag  = {$urandom(), $urandom(), 16'(idx)};
        ar_n = 0; aw_n = 0; w_n = 0;
        ar_a = '0; aw_a = '0; w_d = '0; w_s = '0;
        @(negedge clk);
        in_valid = 1'b1; in_ren = v.ren; in_wen = v.wen; in_size = v.size;
        in_signed = v.sgn; in_addr = v.addr; in_wdata = v.wdata; in_tag = tag;
        rdata = v.rdata; rresp = v.resp; bresp = v.resp;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            if (arvalid && arready) begin ar_n++; ar_a = araddr; end
            if (awvalid && awready) begin aw_n++; aw_a = awaddr; end
            if (wvalid && wready)   begin w_n++;  w_d = wdata; w_s = wstrb; end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput($sformatf("v%0d_lat", idx), 128'(lat), 128'(v.exp_lat));
        checkOutput($sformatf("v%0d_rdata", idx), 128'(out_rdata), 128'(v.exp_rdata));
        checkOutput($sformatf("v%0d_fault", idx), 128'(out_fault), 128'(v.exp_fault));
        checkOutput($sformatf("v%0d_tag", idx), 128'(out_tag), 128'(tag));
        checkOutput($sformatf("v%0d_ar_count", idx), 128'(ar_n), 128'(v.exp_ar ? 1 : 0));
        checkOutput($sformatf("v%0d_aw_count", idx), 128'(aw_n), 128'(v.exp_w ? 1 : 0));
        checkOutput($sformatf("v%0d_w_count", idx), 128'(w_n), 128'(v.exp_w ? 1 : 0));
        if (v.exp_ar) checkOutput($sformatf("v%0d_araddr", idx), 128'(ar_a), 128'(v.addr));
        if (v.exp_w) begin
            checkOutput($sformatf("v%0d_awaddr", idx), 128'(aw_a), 128'(v.addr));
            checkOutput($sformatf("v%0d_wstrb", idx), 128'(w_s), 128'(v.exp_wstrb));
            checkOutput($sformatf("v%0d_wdata", idx), 128'(w_d), 128'(v.exp_wdata));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("v%0d_back_idle", idx), {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [79:0] tag_a, tag_b;
        logic [63:0] cap_wdata;
        logic [7:0]  cap_wstrb;
        logic [31:0] cap_awaddr;
        int          cyc, since, w_n, aw_n;

        in_valid = 0; in_ren = 0; in_wen = 0; in_size = 0; in_signed = 0;
        in_addr = 0; in_wdata = 0; in_tag = 0; out_ready = 0;
        arready = 1; rvalid = 1; rdata = 0; rresp = 0;
        awready = 1; wready = 1; bvalid = 1; bresp = 0;
        d64_in_valid = 0; d64_in_ren = 0; d64_in_wen = 0; d64_in_size = 0; d64_in_signed = 0;
        d64_in_addr = 0; d64_in_wdata = 0; d64_in_tag = 0; d64_out_ready = 0;
        d64_arready = 1; d64_rvalid = 1; d64_rdata = 0; d64_rresp = 0;
        d64_awready = 1; d64_wready = 1; d64_bvalid = 1; d64_bresp = 0;

        //             ren  wen  size sgn  addr          wdata         rdata         resp  exp_rdata     flt  lat ar  w   strb  exp_wdata
        vecs[0]  = '{1'b1,1'b0,2'd0,1'b1,32'h8000_0003,32'h0,        32'h80FF_FF7F,2'd0,32'hFFFF_FF80,1'b0,3,1'b1,1'b0,4'h0,32'h0};
        vecs[1]  = '{1'b1,1'b0,2'd1,1'b0,32'h0000_0002,32'h0,        32'h8001_1234,2'd0,32'h0000_8001,1'b0,3,1'b1,1'b0,4'h0,32'h0};
        vecs[2]  = '{1'b1,1'b0,2'd1,1'b1,32'h0000_0002,32'h0,        32'h8001_1234,2'd0,32'hFFFF_8001,1'b0,3,1'b1,1'b0,4'h0,32'h0};
        vecs[3]  = '{1'b1,1'b0,2'd2,1'b0,32'h0000_0004,32'h0,        32'hDEAD_BEEF,2'd0,32'hDEAD_BEEF,1'b0,3,1'b1,1'b0,4'h0,32'h0};
        vecs[4]  = '{1'b1,1'b0,2'd0,1'b0,32'h0000_0001,32'h0,        32'h0000_A500,2'd2,32'h0,        1'b1,3,1'b1,1'b0,4'h0,32'h0};
        vecs[5]  = '{1'b1,1'b0,2'd2,1'b0,32'h0000_1002,32'h0,        32'h1234_5678,2'd0,32'h0,        1'b1,1,1'b0,1'b0,4'h0,32'h0};
        vecs[6]  = '{1'b0,1'b1,2'd0,1'b0,32'h0000_0005,32'h0000_AB12,32'h0,        2'd0,32'h0,        1'b0,3,1'b0,1'b1,4'h2,32'h1212_1212};
        vecs[7]  = '{1'b0,1'b1,2'd1,1'b0,32'h0000_0002,32'h0000_BEEF,32'h0,        2'd2,32'h0,        1'b1,3,1'b0,1'b1,4'hC,32'hBEEF_BEEF};
        vecs[8]  = '{1'b0,1'b0,2'd2,1'b0,32'h0000_0003,32'h1111_1111,32'h0,        2'd0,32'h0,        1'b0,1,1'b0,1'b0,4'h0,32'h0};
        vecs[9]  = '{1'b0,1'b1,2'd2,1'b0,32'h0000_0008,32'hCAFE_F00D,32'h0,        2'd0,32'h0,        1'b0,3,1'b0,1'b1,4'hF,32'hCAFE_F00D};
        vecs[10] = '{1'b0,1'b1,2'd1,1'b0,32'h0000_0003,32'h0000_1234,32'h0,        2'd0,32'h0,        1'b1,1,1'b0,1'b0,4'h0,32'h0};
        vecs[11] = '{1'b1,1'b1,2'd0,1'b1,32'h0000_0000,32'h0000_0055,32'h0000_007F,2'd0,32'h0000_007F,1'b0,3,1'b1,1'b0,4'h0,32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_held", {arvalid, awvalid, wvalid, rready, bready, out_valid, out_fault, busy}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_state",
            {in_ready, arvalid, awvalid, wvalid, rready, bready, out_valid, out_fault, busy},
            9'b1_0000_0000);
        checkOutput("reset_data", {out_rdata, out_tag}, 112'h0);

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

        // 64-bit store half with AW held off until 3 cycles after the W handshake
        @(negedge clk);
        d64_in_valid = 1; d64_in_wen = 1; d64_in_ren = 0; d64_in_size = 2'd1;
        d64_in_addr = 32'h1006; d64_in_wdata = 64'hBEEF; d64_in_tag = 80'hA5A5;
        d64_awready = 0; d64_wready = 1; d64_bvalid = 1; d64_bresp = 0;
        @(posedge clk); #1;
        d64_in_valid = 0;
        w_n = 0; aw_n = 0; since = -1; cyc = 0;
        cap_wdata = '0; cap_wstrb = '0; cap_awaddr = '0;
        @(negedge clk);
        while (!d64_out_valid && cyc < 30) begin
            if (d64_wvalid && d64_wready) begin w_n++; cap_wdata = d64_wdata; cap_wstrb = d64_wstrb; since = 0; end
            if (d64_awvalid && d64_awready) begin aw_n++; cap_awaddr = d64_awaddr; end
            @(posedge clk); #1;
            if (since >= 0) since++;
            d64_awready = (since >= 3);
            cyc++;
            @(negedge clk);
        end
        checkOutput("st64_lat", 128'(cyc + 1), 128'(6));
        checkOutput("st64_w_count", 128'(w_n), 128'(1));
        checkOutput("st64_aw_count", 128'(aw_n), 128'(1));
        checkOutput("st64_wstrb", 128'(cap_wstrb), 128'(8'hC0));
        checkOutput("st64_wdata", 128'(cap_wdata), 128'(64'hBEEF_BEEF_BEEF_BEEF));
        checkOutput("st64_awaddr", 128'(cap_awaddr), 128'(32'h1006));
        checkOutput("st64_result", {d64_out_fault, d64_out_rdata, d64_out_tag}, {1'b0, 64'h0, 80'hA5A5});
        d64_out_ready = 1;
        @(posedge clk); #1;
        d64_out_ready = 0; d64_awready = 1;

        // 64-bit signed word load from the upper lane
        @(negedge clk);
        d64_in_valid = 1; d64_in_ren = 1; d64_in_wen = 0; d64_in_size = 2'd2; d64_in_signed = 1;
        d64_in_addr = 32'h4; d64_in_tag = 80'h5A5A; d64_rdata = 64'h8765_4321_0000_0000;
        @(posedge clk); #1;
        d64_in_valid = 0;
        cyc = 1;
        @(negedge clk);
        while (!d64_out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("ld64_lat", 128'(cyc), 128'(3));
        checkOutput("ld64_rdata", 128'(d64_out_rdata), 128'(64'hFFFF_FFFF_8765_4321));
        d64_out_ready = 1;
        @(posedge clk); #1;
        d64_out_ready = 0;

        // Backpressure on a pass-through result while the next op waits
        tag_a = {$urandom(), $urandom(), 16'h0BA1};
        tag_b = {$urandom(), $urandom(), 16'h0BA2};
        @(negedge clk);
        in_valid = 1; in_ren = 0; in_wen = 0; in_tag = tag_a; out_ready = 0;
        @(posedge clk); #1;
        in_tag = tag_b;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold%0d", c), {out_valid, in_ready, out_tag}, {1'b1, 1'b0, tag_a});
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        @(negedge clk);
        checkOutput("bp_release", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        checkOutput("bp_resume", {out_valid, out_tag}, {1'b1, tag_b});
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;

        // Reset while waiting for read data
        rvalid = 0; arready = 1;
        @(negedge clk);
        in_valid = 1; in_ren = 1; in_wen = 0; in_size = 2'd2; in_addr = 32'h10;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_pre", {rready, busy, arvalid}, 3'b110);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid", {rready, out_valid, busy, arvalid}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_after", {in_ready, busy}, 2'b10);
        rvalid = 1;
        applyStimulus(vecs[0], 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
